// File: rtl/poly_tone_gen.sv
// Polyphonic square-wave tone generator with per-voice note timers and a
// PWM mixer.
// Each voice turns a 6-bit note code into a square wave. A per-semitone base
// divider runs in series with an octave divider. A shared tick counts down
// the note duration.
module poly_tone_gen #(
  parameter int CLK_HZ  = 100000000,
  parameter int VOICES  = 2,
  parameter int TICK_HZ = 16,
  parameter int DUR_W   = 8,
  parameter int MIX_W   = 7,
  localparam int VW     = (VOICES > 1) ? $clog2(VOICES) : 1
) (
  input  logic              CLK100MHZ,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [VW-1:0]     in_voice,
  input  logic [5:0]        in_note,
  input  logic [DUR_W-1:0]  in_dur,
  output logic [VOICES-1:0] voice_wave,
  output logic [VOICES-1:0] voice_busy,
  output logic              mix_out,
  output logic              tick
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  // Base dividers for semitones A..G#, octave 0 (110 Hz .. 208 Hz).
  localparam int DIV_TAB [12] = '{
    CLK_HZ/512/110 - 1, CLK_HZ/512/117 - 1, CLK_HZ/512/123 - 1,
    CLK_HZ/512/131 - 1, CLK_HZ/512/139 - 1, CLK_HZ/512/147 - 1,
    CLK_HZ/512/156 - 1, CLK_HZ/512/165 - 1, CLK_HZ/512/175 - 1,
    CLK_HZ/512/185 - 1, CLK_HZ/512/196 - 1, CLK_HZ/512/208 - 1
  };
  // The lowest note has the largest divider, so it sets the counter width.
  localparam int DIV_MAX  = CLK_HZ/512/110 - 1;
  localparam int NW       = (DIV_MAX > 0) ? $clog2(DIV_MAX + 1) : 1;

  function automatic logic [NW-1:0] noteDiv(input logic [5:0] code);
    logic [3:0] semi;
    semi    = 4'(code % 6'd12);
    noteDiv = NW'(DIV_TAB[semi]);
  endfunction

  function automatic logic [7:0] octReload(input logic [5:0] code);
    logic [2:0] oct;
    oct       = 3'(code / 6'd12);
    octReload = 8'hFF >> oct;
  endfunction

  logic [TW-1:0]                 tickCnt_q, tickCnt_d;
  logic                          tick_q, tick_d;
  logic [VOICES-1:0]             busy_q, busy_d;
  logic [VOICES-1:0]             wave_q, wave_d;
  logic [VOICES-1:0][5:0]        note_q, note_d;
  logic [VOICES-1:0][DUR_W-1:0]  remain_q, remain_d;
  logic [VOICES-1:0][NW-1:0]     noteCnt_q, noteCnt_d;
  logic [VOICES-1:0][7:0]        octCnt_q, octCnt_d;
  logic [MIX_W-1:0]              phase_q, phase_d;
  logic [MIX_W-1:0]              highCount;
  logic                          mix_q, mix_d;
  logic                          inReady;
  logic                          accept;

  // A voice index with no matching voice never reports ready.
  always_comb begin
    inReady = 1'b0;
    for (int v = 0; v < VOICES; v++) begin
      if (in_voice == VW'(v)) begin
        inReady = ~busy_q[v];
      end
    end
  end

  assign accept = in_valid & inReady;

  // The tick strobe comes from a free-running counter that wraps every TICK_DIV cycles.
  always_comb begin
    tick_d    = (tickCnt_q == TW'(TICK_DIV - 1));
    tickCnt_d = tick_d ? '0 : tickCnt_q + TW'(1);
  end

  // Each voice either loads a new note, times out, or runs its divider chain.
  always_comb begin
    busy_d    = busy_q;
    wave_d    = wave_q;
    note_d    = note_q;
    remain_d  = remain_q;
    noteCnt_d = noteCnt_q;
    octCnt_d  = octCnt_q;
    for (int v = 0; v < VOICES; v++) begin
      if (accept && (in_voice == VW'(v))) begin
        busy_d[v]    = 1'b1;
        wave_d[v]    = 1'b0;
        note_d[v]    = in_note;
        remain_d[v]  = in_dur;
        noteCnt_d[v] = noteDiv(in_note);
        octCnt_d[v]  = octReload(in_note);
      end else if (busy_q[v]) begin
        if (tick_q && (remain_q[v] <= DUR_W'(1))) begin
          busy_d[v]    = 1'b0;
          wave_d[v]    = 1'b0;
          note_d[v]    = '0;
          remain_d[v]  = '0;
          noteCnt_d[v] = '0;
          octCnt_d[v]  = '0;
        end else begin
          if (tick_q) begin
            remain_d[v] = remain_q[v] - DUR_W'(1);
          end
          if (noteCnt_q[v] == '0) begin
            noteCnt_d[v] = noteDiv(note_q[v]);
            if (octCnt_q[v] == 8'd0) begin
              octCnt_d[v] = octReload(note_q[v]);
              if (note_q[v] != 6'd0) begin
                wave_d[v] = ~wave_q[v];
              end
            end else begin
              octCnt_d[v] = octCnt_q[v] - 8'd1;
            end
          end else begin
            noteCnt_d[v] = noteCnt_q[v] - NW'(1);
          end
        end
      end else begin
        wave_d[v]    = 1'b0;
        noteCnt_d[v] = '0;
        octCnt_d[v]  = '0;
      end
    end
  end

  // The mixer is high for n of every 2^MIX_W cycles, where n is the number of high waves.
  always_comb begin
    highCount = '0;
    for (int v = 0; v < VOICES; v++) begin
      highCount = highCount + MIX_W'(wave_q[v]);
    end
    phase_d = phase_q + MIX_W'(1);
    mix_d   = (phase_q < highCount);
  end

  // All state registers; reset aborts every note immediately.
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      tickCnt_q <= '0;
      tick_q    <= 1'b0;
      busy_q    <= '0;
      wave_q    <= '0;
      note_q    <= '0;
      remain_q  <= '0;
      noteCnt_q <= '0;
      octCnt_q  <= '0;
      phase_q   <= '0;
      mix_q     <= 1'b0;
    end else begin
      tickCnt_q <= tickCnt_d;
      tick_q    <= tick_d;
      busy_q    <= busy_d;
      wave_q    <= wave_d;
      note_q    <= note_d;
      remain_q  <= remain_d;
      noteCnt_q <= noteCnt_d;
      octCnt_q  <= octCnt_d;
      phase_q   <= phase_d;
      mix_q     <= mix_d;
    end
  end

  assign in_ready   = inReady;
  assign voice_wave = wave_q;
  assign voice_busy = busy_q;
  assign mix_out    = mix_q;
  assign tick       = tick_q;

endmodule

// File: tb/tb_poly_tone_gen.sv
// Directed testbench for poly_tone_gen, built with a small clock so that
// ticks and tones fit in a short run.
module tb_poly_tone_gen;

  localparam int CLK_HZ      = 1000000;
  localparam int VOICES      = 2;
  localparam int TICK_HZ     = 10000;
  localparam int DUR_W       = 8;
  localparam int MIX_W       = 7;
  localparam int TICK_PERIOD = CLK_HZ / TICK_HZ;
  localparam int DIV_A       = CLK_HZ/512/110 - 1;
  localparam int HALF_P12    = (DIV_A + 1) * ((255 >> 1) + 1);

  typedef struct {
    logic       valid;
    logic [0:0] voice;
    logic [5:0] note;
    logic [7:0] dur;
    logic       expReady;
    logic [1:0] expBusy;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [0:0] in_voice = 1'b0;
  logic [5:0] in_note = 6'd0;
  logic [7:0] in_dur = 8'd0;
  logic       in_ready;
  logic [1:0] voice_wave;
  logic [1:0] voice_busy;
  logic       mix_out;
  logic       tick;

  int total = 0;
  int bad = 0;

  poly_tone_gen #(
    .CLK_HZ(CLK_HZ), .VOICES(VOICES), .TICK_HZ(TICK_HZ),
    .DUR_W(DUR_W), .MIX_W(MIX_W)
  ) dut (
    .CLK100MHZ(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_voice(in_voice),
    .in_note(in_note),
    .in_dur(in_dur),
    .voice_wave(voice_wave),
    .voice_busy(voice_busy),
    .mix_out(mix_out),
    .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [0:0] voice,
                               input logic [5:0] note, input logic [7:0] dur);
    in_valid = v;
    in_voice = voice;
    in_note  = note;
    in_dur   = dur;
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 6'd0, 8'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic waitTick(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3 * TICK_PERIOD; i++) begin
      @(negedge clk);
      if (tick) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic waitWave(input logic [1:0] pattern, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (voice_wave == pattern) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic countMix(output int n);
    n = 0;
    repeat (128) begin
      @(negedge clk);
      n += int'(mix_out);
    end
  endtask

  initial begin
    #3ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs [7];
    logic [1:0] expAfterTick [5];
    bit ok;
    int cnt;
    int ticks;
    int riseAt;
    int fallAt;
    bit pend;
    bit finished;
    bit waveSeen;
    logic prevWave;

    vecs[0] = '{1'b0, 1'b0, 6'd0,  8'd0, 1'b1, 2'b00};
    vecs[1] = '{1'b0, 1'b1, 6'd0,  8'd0, 1'b1, 2'b00};
    vecs[2] = '{1'b1, 1'b0, 6'd63, 8'd5, 1'b1, 2'b01};
    vecs[3] = '{1'b1, 1'b0, 6'd1,  8'd2, 1'b0, 2'b01};
    vecs[4] = '{1'b1, 1'b1, 6'd0,  8'd4, 1'b1, 2'b11};
    vecs[5] = '{1'b1, 1'b1, 6'd7,  8'd9, 1'b0, 2'b11};
    vecs[6] = '{1'b0, 1'b0, 6'd0,  8'd0, 1'b0, 2'b11};
    expAfterTick = '{2'b11, 2'b11, 2'b11, 2'b01, 2'b00};

    // Reset state.
    doReset();
    @(negedge clk);
    checkOutput("rst_busy", int'(voice_busy), 0);
    checkOutput("rst_wave", int'(voice_wave), 0);
    checkOutput("rst_mix", int'(mix_out), 0);
    checkOutput("rst_tick", int'(tick), 0);
    applyStimulus(1'b0, 1'b0, 6'd0, 8'd0);
    #1 checkOutput("rst_ready_v0", int'(in_ready), 1);
    applyStimulus(1'b0, 1'b1, 6'd0, 8'd0);
    #1 checkOutput("rst_ready_v1", int'(in_ready), 1);

    // Tick period and width.
    waitTick(ok);
    checkOutput("tick_seen", int'(ok), 1);
    cnt = 0;
    for (int i = 1; i <= 3 * TICK_PERIOD; i++) begin
      @(negedge clk);
      if (i == 1) checkOutput("tick_width", int'(tick), 0);
      if (tick) begin
        cnt = i;
        break;
      end
    end
    checkOutput("tick_period", cnt, TICK_PERIOD);

    // Command table, applied just after a tick so no tick lands mid-table.
    doReset();
    waitTick(ok);
    checkOutput("table_sync", int'(ok), 1);
    for (int r = 0; r < 7; r++) begin
      applyStimulus(vecs[r].valid, vecs[r].voice, vecs[r].note, vecs[r].dur);
      #1 checkOutput($sformatf("row%0d_ready", r), int'(in_ready), int'(vecs[r].expReady));
      @(negedge clk);
      checkOutput($sformatf("row%0d_busy", r), int'(voice_busy), int'(vecs[r].expBusy));
      checkOutput($sformatf("row%0d_wave", r), int'(voice_wave), 0);
    end
    applyStimulus(1'b0, 1'b0, 6'd0, 8'd0);
    for (int t = 0; t < 5; t++) begin
      waitTick(ok);
      checkOutput($sformatf("tbl_tick%0d_seen", t + 1), int'(ok), 1);
      @(negedge clk);
      checkOutput($sformatf("tbl_tick%0d_busy", t + 1), int'(voice_busy), int'(expAfterTick[t]));
      checkOutput($sformatf("tbl_tick%0d_restWave", t + 1), int'(voice_wave[1]), 0);
    end

    // Note 12 for 50 ticks: toggle timing and end of note.
    doReset();
    applyStimulus(1'b1, 1'b0, 6'd12, 8'd50);
    ticks = 0; riseAt = -1; fallAt = -1; pend = 1'b0; finished = 1'b0; prevWave = 1'b0;
    for (int c = 1; c <= 7000 && !finished; c++) begin
      @(negedge clk);
      if (c == 1) applyStimulus(1'b0, 1'b0, 6'd0, 8'd0);
      if (pend) begin
        pend = 1'b0;
        if (ticks == 49) checkOutput("n12_busy_tick49", int'(voice_busy[0]), 1);
        if (ticks == 50) begin
          checkOutput("n12_busy_end", int'(voice_busy[0]), 0);
          checkOutput("n12_wave_end", int'(voice_wave[0]), 0);
          finished = 1'b1;
        end
      end
      if (voice_wave[0] && !prevWave && riseAt < 0) riseAt = c;
      if (!voice_wave[0] && prevWave && fallAt < 0) fallAt = c;
      prevWave = voice_wave[0];
      if (tick) begin
        ticks++;
        pend = 1'b1;
      end
    end
    checkOutput("n12_finished", int'(finished), 1);
    checkOutput("n12_first_rise", riseAt, HALF_P12 + 1);
    checkOutput("n12_half_period", fallAt - riseAt, HALF_P12);

    // Rest for 3 ticks: wave stays low, ready returns the cycle after the last tick.
    doReset();
    applyStimulus(1'b1, 1'b0, 6'd0, 8'd3);
    ticks = 0; pend = 1'b0; finished = 1'b0; waveSeen = 1'b0;
    for (int c = 1; c <= 600 && !finished; c++) begin
      @(negedge clk);
      if (c == 1) applyStimulus(1'b0, 1'b0, 6'd0, 8'd0);
      if (voice_wave[0]) waveSeen = 1'b1;
      if (pend) begin
        pend = 1'b0;
        if (ticks == 3) begin
          checkOutput("rest_busy_end", int'(voice_busy[0]), 0);
          checkOutput("rest_ready_after", int'(in_ready), 1);
          finished = 1'b1;
        end
      end
      if (tick && !finished) begin
        ticks++;
        pend = 1'b1;
        if (ticks == 3) begin
          checkOutput("rest_busy_on_tick", int'(voice_busy[0]), 1);
          checkOutput("rest_ready_on_tick", int'(in_ready), 0);
        end
      end
    end
    checkOutput("rest_finished", int'(finished), 1);
    checkOutput("rest_wave_low", int'(waveSeen), 0);

    // Accept on the same cycle as a tick: that tick is ignored.
    doReset();
    waitTick(ok);
    checkOutput("coinc_sync", int'(ok), 1);
    applyStimulus(1'b1, 1'b0, 6'd5, 8'd2);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 6'd0, 8'd0);
    checkOutput("coinc_loaded", int'(voice_busy[0]), 1);
    waitTick(ok);
    @(negedge clk);
    checkOutput("coinc_busy_tick1", int'(voice_busy[0]), 1);
    waitTick(ok);
    @(negedge clk);
    checkOutput("coinc_busy_tick2", int'(voice_busy[0]), 0);

    // Mixer duty with zero, one and two waves high.
    doReset();
    countMix(cnt);
    checkOutput("mix_none", cnt, 0);
    applyStimulus(1'b1, 1'b0, 6'd1, 8'd200);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 6'd0, 8'd0);
    repeat (299) @(negedge clk);
    applyStimulus(1'b1, 1'b1, 6'd1, 8'd200);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 6'd0, 8'd0);
    waitWave(2'b01, 6000, ok);
    checkOutput("mix_one_seen", int'(ok), 1);
    repeat (2) @(negedge clk);
    countMix(cnt);
    checkOutput("mix_one", cnt, 1);
    waitWave(2'b11, 1000, ok);
    checkOutput("mix_two_seen", int'(ok), 1);
    repeat (2) @(negedge clk);
    countMix(cnt);
    checkOutput("mix_two", cnt, 2);

    // Reset pulsed mid-note.
    doReset();
    applyStimulus(1'b1, 1'b0, 6'd63, 8'd100);
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 6'd1, 8'd100);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 6'd0, 8'd0);
    waitWave(2'b01, 300, ok);
    checkOutput("midrst_wave_seen", int'(ok), 1);
    checkOutput("midrst_busy_before", int'(voice_busy), 3);
    #2 reset = 1'b1;
    #1;
    checkOutput("midrst_busy", int'(voice_busy), 0);
    checkOutput("midrst_wave", int'(voice_wave), 0);
    checkOutput("midrst_mix", int'(mix_out), 0);
    checkOutput("midrst_tick", int'(tick), 0);
    checkOutput("midrst_ready_v0", int'(in_ready), 1);
    applyStimulus(1'b0, 1'b1, 6'd0, 8'd0);
    #1 checkOutput("midrst_ready_v1", int'(in_ready), 1);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b1, 1'b1, 6'd0, 8'd1);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 6'd0, 8'd0);
    checkOutput("midrst_new_accept", int'(voice_busy), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
